// File: rtl/status_reg_pkg.sv
// Shared definitions for the 6502 status register: flag bit positions,
// flag-instruction encodings and the power-on value of P.
package status_reg_pkg;

   localparam int CARRY    = 0;
   localparam int ZERO     = 1;
   localparam int IRQ_DIS  = 2;
   localparam int DECIMAL  = 3;
   localparam int BRK      = 4;
   localparam int UNUSED   = 5;
   localparam int OVERFLOW = 6;
   localparam int NEG      = 7;

   localparam logic [7:0] P_RESET = 8'h34;

   typedef enum logic [2:0] {
      FOP_NONE = 3'd0,
      FOP_CLC  = 3'd1,
      FOP_SEC  = 3'd2,
      FOP_CLI  = 3'd3,
      FOP_SEI  = 3'd4,
      FOP_CLD  = 3'd5,
      FOP_SED  = 3'd6,
      FOP_CLV  = 3'd7
   } flag_op_e;

endpackage

// File: rtl/status_reg_branch_eval.sv
// Branch condition evaluator: opcode[7:5] picks N/V/C/Z and the polarity
// the flag must have for the branch to be taken.
module status_reg_branch_eval
   import status_reg_pkg::*;
(
   input  logic [7:0] p,
   input  logic [2:0] br_cond,
   output logic       br_taken
);

   logic flag;
   logic unused_p;

   assign unused_p = ^p[5:2];

   always_comb begin
      flag = p[NEG];
      case (br_cond[2:1])
         2'b00:   flag = p[NEG];
         2'b01:   flag = p[OVERFLOW];
         2'b10:   flag = p[CARRY];
         default: flag = p[ZERO];
      endcase
      br_taken = (flag == br_cond[0]);
   end

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register (P). Define DECIMAL_MODE_EN to drive
// alu_BCD from the D flag; otherwise alu_BCD is tied low (2A03-style core).
module status_reg
   import status_reg_pkg::*;
#(
   parameter logic [7:0] RESET_P        = P_RESET,
   parameter int         IRQ_MASK_DELAY = 1
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] alu_flags,
   input  logic       flag_upd,
   input  logic [7:0] flag_upd_mask,
   input  logic [2:0] flag_op,
   input  logic       p_load,
   input  logic [7:0] p_load_data,
   input  logic       push_brk,
   input  logic [2:0] br_cond,
   output logic [7:0] p_out,
   output logic [7:0] p_push,
   output logic       alu_carry,
   output logic       alu_BCD,
   output logic       irq_mask,
   output logic       br_taken
);

   logic c, z, i, d, v, n;
   logic c_nxt, z_nxt, i_nxt, d_nxt, v_nxt, n_nxt;
   logic unused_bits;

   // B and bit 5 are not stored, so their input bits are dropped here.
   assign unused_bits = ^{alu_flags[5:2], flag_upd_mask[5:2], p_load_data[5:4]};

   always_comb begin
      c_nxt = c;
      z_nxt = z;
      i_nxt = i;
      d_nxt = d;
      v_nxt = v;
      n_nxt = n;
      if (p_load) begin
         c_nxt = p_load_data[CARRY];
         z_nxt = p_load_data[ZERO];
         i_nxt = p_load_data[IRQ_DIS];
         d_nxt = p_load_data[DECIMAL];
         v_nxt = p_load_data[OVERFLOW];
         n_nxt = p_load_data[NEG];
      end else begin
         if (flag_upd) begin
            if (flag_upd_mask[CARRY])    c_nxt = alu_flags[CARRY];
            if (flag_upd_mask[ZERO])     z_nxt = alu_flags[ZERO];
            if (flag_upd_mask[OVERFLOW]) v_nxt = alu_flags[OVERFLOW];
            if (flag_upd_mask[NEG])      n_nxt = alu_flags[NEG];
         end
         // The explicit flag instruction is applied last so it wins on its bit.
         case (flag_op_e'(flag_op))
            FOP_CLC: c_nxt = 1'b0;
            FOP_SEC: c_nxt = 1'b1;
            FOP_CLI: i_nxt = 1'b0;
            FOP_SEI: i_nxt = 1'b1;
            FOP_CLD: d_nxt = 1'b0;
            FOP_SED: d_nxt = 1'b1;
            FOP_CLV: v_nxt = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c <= RESET_P[CARRY];
         z <= RESET_P[ZERO];
         i <= RESET_P[IRQ_DIS];
         d <= RESET_P[DECIMAL];
         v <= RESET_P[OVERFLOW];
         n <= RESET_P[NEG];
      end else begin
         c <= c_nxt;
         z <= z_nxt;
         i <= i_nxt;
         d <= d_nxt;
         v <= v_nxt;
         n <= n_nxt;
      end
   end

   assign p_out     = {n, v, 1'b1, 1'b1,     d, i, z, c};
   assign p_push    = {n, v, 1'b1, push_brk, d, i, z, c};
   assign alu_carry = c;

`ifdef DECIMAL_MODE_EN
   assign alu_BCD = d;
`else
   assign alu_BCD = 1'b0;
`endif

   generate
      if (IRQ_MASK_DELAY != 0) begin : g_irq_dly
         logic irq_mask_p1;
         // Stage boundary: interrupt logic sees I one clock late.
         always_ff @(posedge clk) begin
            if (rst) irq_mask_p1 <= 1'b1;
            else     irq_mask_p1 <= i;
         end
         assign irq_mask = irq_mask_p1;
      end else begin : g_irq_comb
         assign irq_mask = i;
      end
   endgenerate

   status_reg_branch_eval u_branch_eval (
      .p        (p_out),
      .br_cond  (br_cond),
      .br_taken (br_taken)
   );

endmodule

// File: tb/tb_status_reg.sv
// Directed bench for status_reg: reset, masked update, op collisions,
// irq_mask latency, push formatting, branch evaluation and decimal config.
module tb_status_reg;
   import status_reg_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] alu_flags;
   logic       flag_upd;
   logic [7:0] flag_upd_mask;
   logic [2:0] flag_op;
   logic       p_load;
   logic [7:0] p_load_data;
   logic       push_brk;
   logic [2:0] br_cond;
   logic [7:0] p_out;
   logic [7:0] p_push;
   logic       alu_carry;
   logic       alu_bcd;
   logic       irq_mask;
   logic       br_taken;

   int checks;
   int errors;

   status_reg dut (
      .clk           (clk),
      .rst           (rst),
      .alu_flags     (alu_flags),
      .flag_upd      (flag_upd),
      .flag_upd_mask (flag_upd_mask),
      .flag_op       (flag_op),
      .p_load        (p_load),
      .p_load_data   (p_load_data),
      .push_brk      (push_brk),
      .br_cond       (br_cond),
      .p_out         (p_out),
      .p_push        (p_push),
      .alu_carry     (alu_carry),
      .alu_BCD       (alu_bcd),
      .irq_mask      (irq_mask),
      .br_taken      (br_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      rst           = 1'b0;
      alu_flags     = 8'h00;
      flag_upd      = 1'b0;
      flag_upd_mask = 8'h00;
      flag_op       = FOP_NONE;
      p_load        = 1'b0;
      p_load_data   = 8'h00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      push_brk = 1'b0;
      br_cond  = 3'b000;
      #1;
      checks++; if (p_out !== 8'h34) begin errors++; $display("FAIL reset_p_out: got %h expected %h", p_out, 8'h34); end
      checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL reset_irq_mask: got %b expected 1", irq_mask); end
      checks++; if (alu_carry !== 1'b0) begin errors++; $display("FAIL reset_alu_carry: got %b expected 0", alu_carry); end
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL reset_bpl_taken: got %b expected 1", br_taken); end
      checks++; if (p_push !== 8'h24) begin errors++; $display("FAIL reset_p_push: got %h expected %h", p_push, 8'h24); end
      checks++; if (alu_bcd !== 1'b0) begin errors++; $display("FAIL reset_alu_bcd: got %b expected 0", alu_bcd); end
      // reset must override a same-cycle load
      p_load = 1'b1; p_load_data = 8'hFF;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'hFF) begin errors++; $display("FAIL load_before_override: got %h expected %h", p_out, 8'hFF); end
      rst = 1'b1; p_load = 1'b1; p_load_data = 8'h00; flag_op = FOP_SEC;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h34) begin errors++; $display("FAIL reset_override: got %h expected %h", p_out, 8'h34); end
   endtask

   task automatic test_masked_update();
      do_reset();
      alu_flags = 8'hC3; flag_upd_mask = 8'h83; flag_upd = 1'b1;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'hB7) begin errors++; $display("FAIL masked_update: got %h expected %h", p_out, 8'hB7); end
      tick();
      checks++; if (p_out !== 8'hB7) begin errors++; $display("FAIL idle_hold: got %h expected %h", p_out, 8'hB7); end
      // mask bits 5..2 must be ignored; flag_upd with zero mask changes nothing
      alu_flags = 8'h00; flag_upd_mask = 8'h3C; flag_upd = 1'b1;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'hB7) begin errors++; $display("FAIL ignored_mask_bits: got %h expected %h", p_out, 8'hB7); end
      // V only
      alu_flags = 8'h40; flag_upd_mask = 8'h40; flag_upd = 1'b1;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'hF7) begin errors++; $display("FAIL v_update: got %h expected %h", p_out, 8'hF7); end
      // P = F7: N=1 V=1 C=1 Z=1
      br_cond = 3'b001; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL bmi: got %b expected 1", br_taken); end
      br_cond = 3'b000; #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bpl: got %b expected 0", br_taken); end
      br_cond = 3'b010; #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bvc: got %b expected 0", br_taken); end
      br_cond = 3'b011; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL bvs: got %b expected 1", br_taken); end
      br_cond = 3'b100; #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bcc: got %b expected 0", br_taken); end
      br_cond = 3'b111; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL beq: got %b expected 1", br_taken); end
      br_cond = 3'b110; #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bne: got %b expected 0", br_taken); end
      // clear Z and C only: BNE and BCC now taken
      alu_flags = 8'hFC; flag_upd_mask = 8'h03; flag_upd = 1'b1;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'hF4) begin errors++; $display("FAIL zc_clear: got %h expected %h", p_out, 8'hF4); end
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL bne_taken: got %b expected 1", br_taken); end
      br_cond = 3'b100; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL bcc_taken: got %b expected 1", br_taken); end
   endtask

   task automatic test_collision();
      do_reset();
      alu_flags = 8'h00; flag_upd_mask = 8'h01; flag_upd = 1'b1; flag_op = FOP_SEC;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h35) begin errors++; $display("FAIL upd_vs_sec: got %h expected %h", p_out, 8'h35); end
      checks++; if (alu_carry !== 1'b1) begin errors++; $display("FAIL upd_vs_sec_carry: got %b expected 1", alu_carry); end
      // flag_upd sets V while CLC in same cycle clears C: both take effect
      alu_flags = 8'h41; flag_upd_mask = 8'h41; flag_upd = 1'b1; flag_op = FOP_CLC;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h74) begin errors++; $display("FAIL upd_vs_clc: got %h expected %h", p_out, 8'h74); end
      p_load = 1'b1; p_load_data = 8'h00; flag_op = FOP_SEC;
      alu_flags = 8'hFF; flag_upd_mask = 8'hFF; flag_upd = 1'b1;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h30) begin errors++; $display("FAIL load_vs_sec: got %h expected %h", p_out, 8'h30); end
      flag_op = FOP_CLV;
      p_load = 1'b1; p_load_data = 8'h40;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h70) begin errors++; $display("FAIL load_vs_clv: got %h expected %h", p_out, 8'h70); end
      flag_op = FOP_CLV;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h30) begin errors++; $display("FAIL clv: got %h expected %h", p_out, 8'h30); end
   endtask

   task automatic test_irq_latency();
      do_reset();
      flag_op = FOP_CLI;
      tick();
      idle_inputs();
      checks++; if (p_out[2] !== 1'b0) begin errors++; $display("FAIL cli_p_i: got %b expected 0", p_out[2]); end
      checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL cli_mask_1clk: got %b expected 1", irq_mask); end
      tick();
      checks++; if (irq_mask !== 1'b0) begin errors++; $display("FAIL cli_mask_2clk: got %b expected 0", irq_mask); end
      flag_op = FOP_SEI;
      tick();
      checks++; if (p_out[2] !== 1'b1) begin errors++; $display("FAIL sei_p_i: got %b expected 1", p_out[2]); end
      checks++; if (irq_mask !== 1'b0) begin errors++; $display("FAIL sei_mask_lag: got %b expected 0", irq_mask); end
      flag_op = FOP_CLI;
      tick();
      idle_inputs();
      checks++; if (p_out[2] !== 1'b0) begin errors++; $display("FAIL sei_cli_p_i: got %b expected 0", p_out[2]); end
      checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL sei_cli_pulse: got %b expected 1", irq_mask); end
      tick();
      checks++; if (irq_mask !== 1'b0) begin errors++; $display("FAIL sei_cli_pulse_end: got %b expected 0", irq_mask); end
   endtask

   task automatic test_push_format();
      do_reset();
      flag_op = FOP_SEC;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h35) begin errors++; $display("FAIL push_setup: got %h expected %h", p_out, 8'h35); end
      push_brk = 1'b0; #1;
      checks++; if (p_push !== 8'h25) begin errors++; $display("FAIL push_irq: got %h expected %h", p_push, 8'h25); end
      push_brk = 1'b1; #1;
      checks++; if (p_push !== 8'h35) begin errors++; $display("FAIL push_brk: got %h expected %h", p_push, 8'h35); end
      p_load = 1'b1; p_load_data = 8'hFF;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'hFF) begin errors++; $display("FAIL plp_ff: got %h expected %h", p_out, 8'hFF); end
      push_brk = 1'b0; #1;
      checks++; if (p_push !== 8'hEF) begin errors++; $display("FAIL push_ff_irq: got %h expected %h", p_push, 8'hEF); end
      // bits 5 and 4 of the pulled byte are discarded
      p_load = 1'b1; p_load_data = 8'h00;
      tick();
      idle_inputs();
      checks++; if (p_out !== 8'h30) begin errors++; $display("FAIL plp_00: got %h expected %h", p_out, 8'h30); end
      checks++; if (p_push !== 8'h20) begin errors++; $display("FAIL push_00_irq: got %h expected %h", p_push, 8'h20); end
   endtask

   task automatic test_decimal();
      logic exp_bcd;
`ifdef DECIMAL_MODE_EN
      exp_bcd = 1'b1;
`else
      exp_bcd = 1'b0;
`endif
      do_reset();
      flag_op = FOP_SED;
      tick();
      idle_inputs();
      checks++; if (p_out[3] !== 1'b1) begin errors++; $display("FAIL sed_p_d: got %b expected 1", p_out[3]); end
      checks++; if (alu_bcd !== exp_bcd) begin errors++; $display("FAIL sed_alu_bcd: got %b expected %b", alu_bcd, exp_bcd); end
      checks++; if (p_out !== 8'h3C) begin errors++; $display("FAIL sed_p_out: got %h expected %h", p_out, 8'h3C); end
      flag_op = FOP_CLD;
      tick();
      idle_inputs();
      checks++; if (p_out[3] !== 1'b0) begin errors++; $display("FAIL cld_p_d: got %b expected 0", p_out[3]); end
      checks++; if (alu_bcd !== 1'b0) begin errors++; $display("FAIL cld_alu_bcd: got %b expected 0", alu_bcd); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      push_brk = 1'b0;
      br_cond  = 3'b000;
      idle_inputs();
      test_reset();
      test_masked_update();
      test_collision();
      test_irq_latency();
      test_push_format();
      test_decimal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
